// File: rtl/sram_xbar_n.sv
// Address-decoding crossbar from one SRAM-style master port to N_SLAVE SRAM slaves.
// Read data is steered back after LATENCY cycles and held while idle; unmapped accesses are logged.
module sram_xbar_n #(
  parameter int                          LEN_ADDR     = 64,
  parameter int                          LEN_DATA     = 64,
  parameter int                          N_SLAVE      = 4,
  parameter int                          LATENCY      = 1,
  parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_BASE   = '0,
  parameter logic [N_SLAVE*LEN_ADDR-1:0] SLAVE_MASK   = '0,
  parameter logic [LEN_DATA-1:0]         DEFAULT_DATA = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LEN_ADDR-1:0]             master_addra,
  input  logic [LEN_DATA-1:0]             master_dina,
  input  logic                            master_ena,
  input  logic [LEN_DATA/8-1:0]           master_wea,
  output logic [LEN_DATA-1:0]             master_douta,
  output logic [N_SLAVE*LEN_ADDR-1:0]     slave_addra,
  output logic [N_SLAVE*LEN_DATA-1:0]     slave_dina,
  output logic [N_SLAVE-1:0]              slave_ena,
  output logic [N_SLAVE*(LEN_DATA/8)-1:0] slave_wea,
  input  logic [N_SLAVE*LEN_DATA-1:0]     slave_douta,
  output logic                            err_valid,
  output logic [LEN_ADDR-1:0]             err_addr,
  output logic                            err_write,
  output logic [7:0]                      err_count,
  input  logic                            err_clear
);

  localparam int LEN_WE = LEN_DATA / 8;
  localparam int SEL_W  = $clog2(N_SLAVE + 1);
  localparam logic [SEL_W-1:0] SEL_MISS = SEL_W'(N_SLAVE);

  logic [N_SLAVE-1:0] hit;
  logic [N_SLAVE-1:0] win_oh;
  logic [SEL_W-1:0]   win_sel;
  logic               found;
  logic               miss;

  logic               stage_valid;
  logic [SEL_W-1:0]   stage_sel;
  logic [SEL_W-1:0]   out_sel_q;

  logic               err_valid_q, err_valid_d;
  logic [LEN_ADDR-1:0] err_addr_q, err_addr_d;
  logic               err_write_q, err_write_d;
  logic [7:0]         err_count_q, err_count_d;

  // Address/data fan out unchanged; only enables and byte-writes are steered.
  for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_slave
    assign hit[gi] = (master_addra & SLAVE_MASK[gi*LEN_ADDR +: LEN_ADDR])
                     == SLAVE_BASE[gi*LEN_ADDR +: LEN_ADDR];
    assign slave_addra[gi*LEN_ADDR +: LEN_ADDR] = master_addra;
    assign slave_dina[gi*LEN_DATA +: LEN_DATA]  = master_dina;
    assign slave_ena[gi]                        = master_ena & win_oh[gi];
    assign slave_wea[gi*LEN_WE +: LEN_WE]       = slave_ena[gi] ? master_wea : '0;
  end

  // Lowest hitting index wins on overlapping windows.
  always_comb begin
    found   = 1'b0;
    win_oh  = '0;
    win_sel = SEL_MISS;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (hit[i] && !found) begin
        found     = 1'b1;
        win_oh[i] = 1'b1;
        win_sel   = SEL_W'(i);
      end
    end
  end

  assign miss = master_ena & ~found;

  if (LATENCY == 1) begin : g_lat1
    assign stage_valid = master_ena;
    assign stage_sel   = win_sel;
  end else begin : g_pipe
    logic [LATENCY-2:0] valid_q;
    logic [SEL_W-1:0]   sel_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int i = 0; i < LATENCY - 1; i++) sel_q[i] <= '0;
      end else begin
        valid_q[0] <= master_ena;
        sel_q[0]   <= win_sel;
        for (int i = 1; i < LATENCY - 1; i++) begin
          valid_q[i] <= valid_q[i-1];
          sel_q[i]   <= sel_q[i-1];
        end
      end
    end

    assign stage_valid = valid_q[LATENCY-2];
    assign stage_sel   = sel_q[LATENCY-2];
  end

  // out_sel only moves on a completing request, so idle cycles hold the last read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel_q <= '0;
    end else if (stage_valid) begin
      out_sel_q <= stage_sel;
    end
  end

  always_comb begin
    master_douta = DEFAULT_DATA;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (out_sel_q == SEL_W'(i)) master_douta = slave_douta[i*LEN_DATA +: LEN_DATA];
    end
  end

  // A miss coinciding with err_clear restarts the log with this miss as the first one.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_count_d = err_count_q;
    if (miss) begin
      err_valid_d = 1'b1;
      if (!err_valid_q || err_clear) begin
        err_addr_d  = master_addra;
        err_write_d = |master_wea;
      end
      if (err_clear) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (err_clear) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_write_d = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign err_count = err_count_q;

endmodule

// File: doc/sram_xbar_n.md
SRAM_XBAR_N -- requirements
Module: sram_xbar_n

Interface
REQ-001 SHALL have parameter LEN_ADDR, default 64, the address width.
REQ-002 SHALL have parameter LEN_DATA, default 64, the data width; write-enable width is LEN_DATA/8.
REQ-003 SHALL have parameter N_SLAVE, default 4, the slave count, legal range 1..8.
REQ-004 SHALL have parameter LATENCY, default 1, the slave read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter SLAVE_BASE, default 0, N_SLAVE packed LEN_ADDR-bit base addresses, with slave i in bits [i*LEN_ADDR +: LEN_ADDR].
REQ-006 SHALL have parameter SLAVE_MASK, default 0, N_SLAVE packed LEN_ADDR-bit decode masks, packed like SLAVE_BASE.
REQ-007 SHALL have parameter DEFAULT_DATA, default 0, the read data returned for unmapped accesses.
REQ-008 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-009 Port rst, input, 1: reset, synchronous and active-high.
REQ-010 Port master_addra/master_dina/master_ena/master_wea, input, LEN_ADDR/LEN_DATA/1/LEN_DATA/8: the master request.
REQ-011 Port master_douta, output, LEN_DATA: read data returned to the master.
REQ-012 Port slave_addra/slave_dina/slave_ena/slave_wea, output, N_SLAVE times LEN_ADDR/LEN_DATA/1/LEN_DATA/8 packed: the per-slave requests.
REQ-013 Port slave_douta, input, N_SLAVE*LEN_DATA packed: the per-slave read data.
REQ-014 Port err_valid, output, 1: sticky flag, set when an unmapped access occurs.
REQ-015 Port err_addr, output, LEN_ADDR: address of the first unmapped access.
REQ-016 Port err_write, output, 1: the first unmapped access was a write (its wea was nonzero).
REQ-017 Port err_count, output, 8: count of unmapped accesses, saturating at 255.
REQ-018 Port err_clear, input, 1: one-cycle pulse that clears err_valid, err_addr, err_write and err_count.

Function
REQ-019 Slave i SHALL hit when (master_addra & MASK_i) == BASE_i; on overlap the lowest hitting index SHALL win; no hit is a miss.
REQ-020 Slave addresses and write data SHALL be fed combinationally to every slave: slave_addra gets master_addra, unchanged and not offset; slave_dina gets master_dina.
REQ-021 slave_ena[i] SHALL equal master_ena AND (i is the winning slave); slave_wea[i] SHALL equal master_wea when slave_ena[i] is 1, else 0.
REQ-022 On a miss, no slave_ena SHALL assert.
REQ-023 Each cycle with master_ena=1 SHALL push the pair (valid=1, sel) into a LATENCY-deep shift pipeline; sel is the winning index, or N_SLAVE for a miss.
REQ-024 Each cycle with master_ena=0 SHALL push valid=0 into the pipeline.
REQ-025 Held register out_sel SHALL load the sel of the pipeline output stage whenever that stage is valid, and otherwise keep its value.
REQ-026 master_douta SHALL be combinational from out_sel: slave_douta[out_sel], or DEFAULT_DATA when out_sel=N_SLAVE.
REQ-027 Read data SHALL therefore appear exactly LATENCY cycles after the request, and SHALL hold while the master is idle, matching single-port SRAM hold behaviour.
REQ-028 Back-to-back requests to different slaves SHALL each return their own slave's data in issue order, with no bubble.
REQ-029 A miss with master_ena=1 while err_valid=0 SHALL, on the next edge, set err_valid=1 and capture err_addr and err_write.
REQ-030 A miss while err_valid=1 SHALL leave err_addr and err_write unchanged.
REQ-031 Every miss with master_ena=1 SHALL increment err_count by 1, saturating at 255.
REQ-032 err_clear and a miss in the same cycle: the miss SHALL win, giving err_valid=1, the new address captured, and err_count=1.
REQ-033 A miss SHALL never produce a write to any slave.

Reset
REQ-034 On rst=1: every pipeline valid SHALL clear to 0, out_sel SHALL be 0, err_valid=0, err_addr=0, err_write=0 and err_count=0.
REQ-035 Reset SHALL dominate master_ena and err_clear; requests in flight are discarded, and after reset master_douta follows slave 0.

Verification
REQ-036 N=3, LATENCY=1; bases 0x0, 0x6000_0000, 0x6400_0000; masks 0xF000_0000, 0xFF00_0000, 0xFF00_0000; read 0x6400_0010 -> only slave_ena[2]=1; next cycle master_douta = slave2 data; held while idle.
REQ-037 LATENCY=3; reads to slave 0, 1, 2 on consecutive cycles -> their data appears on cycles 3, 4, 5 in that order.
REQ-038 Write to 0x7000_0000 with wea=0xFF -> no slave_ena; next cycle err_valid=1, err_addr=0x7000_0000, err_write=1; a later read returns DEFAULT_DATA.
REQ-039 Second miss at 0x9000_0000 -> err_addr unchanged, err_count=2; err_clear together with a miss at 0xA000_0000 -> err_addr=0xA000_0000, err_count=1.
REQ-040 Overlapping masks where slaves 0 and 1 both hit -> slave 0 selected; 300 misses -> err_count=255.
REQ-041 rst asserted while a LATENCY=2 read is in flight -> out_sel=0, err_* all 0, and the discarded read never updates master_douta.
